clk_tick_sched: RTL and testbench

Multi-channel periodic tick scheduler built around a shared prescaler in the clocking subsystem. It produces single-cycle clock-enable strobes at programmable rates, so downstream logic stays on the system clock instead of using divided clocks. Each channel's period and enable are written at runtime through a valid/ready port. Every write is applied on a prescaler boundary, so no channel ever emits a truncated or partial period.

---
 rtl/clk_tick_sched_if.sv | 27 ++
 rtl/clk_tick_sched.sv | 132 +++++++++++++
 tb/tb_clk_tick_sched.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_tick_sched_if.sv
// Configuration write port of the tick scheduler: one valid/ready transfer carries
// a channel index, a period and an enable.
interface clk_tick_sched_if #(
    parameter int CNT_W = 17
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic             cfg_en;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_period,
        output cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_period,
        input  cfg_en,
        output cfg_ready
    );
endinterface

// File: rtl/clk_tick_sched.sv
// Multi-channel periodic clock-enable generator sharing one prescaler; config writes
// land only on a base tick. Optional macro TICK_SCHED_PHASE_ALIGN_EN re-phases all channels on apply.
module clk_tick_sched #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 17,
    parameter int PRESCALE = 2
) (
    input  logic            clk,
    input  logic            rst,
    clk_tick_sched_if.slave cfg,
    output logic [N_CH-1:0] tick_out,
    output logic            busy
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        RESET,
        RUN,
        PEND
    } state_t;

    state_t           r_state;
    logic [PRE_W-1:0] r_pre_cnt;
    logic             r_cfg_ready;
    logic             r_busy;
    logic [1:0]       r_hold_ch;
    logic [CNT_W-1:0] r_hold_period;
    logic             r_hold_en;
    logic [CNT_W-1:0] r_period [N_CH];
    logic [CNT_W-1:0] r_cnt    [N_CH];
    logic [N_CH-1:0]  r_en;
    logic [N_CH-1:0]  r_tick;

    logic             w_base_tick;
    logic             w_apply;
    logic             w_hold_in_range;

    assign w_base_tick     = (r_pre_cnt == PRE_W'(PRESCALE - 1));
    assign w_apply         = (r_state == PEND) && w_base_tick;
    assign w_hold_in_range = (32'(r_hold_ch) < 32'(N_CH));

    assign cfg.cfg_ready = r_cfg_ready;
    assign busy          = r_busy;
    assign tick_out      = r_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt <= '0;
        end else if (w_base_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end

    // A write is captured once, then waits in PEND for the next prescaler boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RESET;
            r_cfg_ready   <= 1'b0;
            r_busy        <= 1'b0;
            r_hold_ch     <= '0;
            r_hold_period <= '0;
            r_hold_en     <= 1'b0;
        end else begin
            case (r_state)
                RESET: begin
                    r_state     <= RUN;
                    r_cfg_ready <= 1'b1;
                end
                RUN: begin
                    if (cfg.cfg_valid && r_cfg_ready) begin
                        r_hold_ch     <= cfg.cfg_ch;
                        r_hold_period <= cfg.cfg_period;
                        r_hold_en     <= cfg.cfg_en;
                        r_state       <= PEND;
                        r_cfg_ready   <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end
                PEND: begin
                    if (w_base_tick) begin
                        r_state     <= RUN;
                        r_cfg_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= RESET;
                    r_cfg_ready <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // The apply target is reloaded instead of counted, so its old phase never leaks a short tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                r_period[i] <= '0;
                r_cnt[i]    <= '0;
            end
            r_en   <= '0;
            r_tick <= '0;
        end else begin
            r_tick <= '0;
            for (int i = 0; i < N_CH; i++) begin
                if (w_apply && w_hold_in_range && (r_hold_ch == 2'(i))) begin
                    r_period[i] <= r_hold_period;
                    r_en[i]     <= r_hold_en;
                    r_cnt[i]    <= '0;
                end else if (!r_en[i] || (r_period[i] == '0)) begin
                    r_cnt[i] <= '0;
`ifdef TICK_SCHED_PHASE_ALIGN_EN
                end else if (w_apply && w_hold_in_range) begin
                    r_cnt[i] <= '0;
`endif
                end else if (w_base_tick) begin
                    if (r_cnt[i] == (r_period[i] - 1'b1)) begin
                        r_cnt[i]  <= '0;
                        r_tick[i] <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_tick_sched.sv
// Scoreboard bench for clk_tick_sched: a 4-channel and a 2-channel instance share one
// write stream; expected ticks and handshake levels are queued at stimulus time.
module tb_clk_tick_sched;

    localparam int CNT_W = 17;
    localparam int PRE   = 4;

    typedef struct {
        int cyc;
        bit ready;
        bit busy;
        bit tickZero;
    } hsExp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tick1;
    logic [1:0] tick2;
    logic       busy1;
    logic       busy2;

    hsExp_t hsQ[$];
    int     tq[6][$];
    int     mPer[6];
    bit     mEn[6];
    int     cyc    = 0;
    int     segEnd = 0;
    int     relCyc = 0;
    int     checks = 0;
    int     errors = 0;

    clk_tick_sched_if #(.CNT_W(CNT_W)) cfgIf ();
    clk_tick_sched_if #(.CNT_W(CNT_W)) cfgIf2 ();

    assign cfgIf2.cfg_valid  = cfgIf.cfg_valid;
    assign cfgIf2.cfg_ch     = cfgIf.cfg_ch;
    assign cfgIf2.cfg_period = cfgIf.cfg_period;
    assign cfgIf2.cfg_en     = cfgIf.cfg_en;

    clk_tick_sched #(.N_CH(4), .CNT_W(CNT_W), .PRESCALE(PRE)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg      (cfgIf.slave),
        .tick_out (tick1),
        .busy     (busy1)
    );

    clk_tick_sched #(.N_CH(2), .CNT_W(CNT_W), .PRESCALE(PRE)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .cfg      (cfgIf2.slave),
        .tick_out (tick2),
        .busy     (busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Cycle c is a base tick when the prescaler, restarted at reset release, reads PRE-1.
    function automatic int applyCycle(input int tCyc);
        int c = tCyc + 1;
        while (((c - relCyc) % PRE) != (PRE - 1)) c++;
        return c;
    endfunction

    task automatic restartChannel(input int idx, input int aCyc);
        while (tq[idx].size() > 0 && tq[idx][$] > aCyc) void'(tq[idx].pop_back());
        if (mEn[idx] && mPer[idx] != 0) begin
            for (int t = aCyc + PRE * mPer[idx] + 1; t <= segEnd; t += PRE * mPer[idx])
                tq[idx].push_back(t);
        end
    endtask

    task automatic modelApply(input int base, input int nch, input int ch, input int period,
                              input bit en, input int aCyc);
        if (ch >= nch) return;
`ifdef TICK_SCHED_PHASE_ALIGN_EN
        for (int c = 0; c < nch; c++)
            if (c != ch && mEn[base + c] && mPer[base + c] != 0) restartChannel(base + c, aCyc);
`endif
        mEn[base + ch]  = en;
        mPer[base + ch] = period;
        restartChannel(base + ch, aCyc);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues one write; data is scrambled right after the accept cycle.
    task automatic applyStimulus(input int ch, input int period, input bit en, input bit hold);
        int waitN = 0;
        int tCyc;
        int aCyc;
        while (cfgIf.cfg_ready !== 1'b1 && waitN < 20) begin
            @(posedge clk);
            #1;
            waitN++;
        end
        if (cfgIf.cfg_ready !== 1'b1) begin
            checkOutput("cfg_ready timeout", 0, 1);
            return;
        end
        cfgIf.cfg_valid  = 1'b1;
        cfgIf.cfg_ch     = 2'(ch);
        cfgIf.cfg_period = CNT_W'(period);
        cfgIf.cfg_en     = en;
        tCyc = cyc;
        aCyc = applyCycle(tCyc);
        for (int c = tCyc + 1; c <= aCyc; c++) hsQ.push_back('{c, 1'b0, 1'b1, 1'b0});
        hsQ.push_back('{aCyc + 1, 1'b1, 1'b0, 1'b0});
        modelApply(0, 4, ch, period, en, aCyc);
        modelApply(4, 2, ch, period, en, aCyc);
        @(posedge clk);
        #1;
        cfgIf.cfg_ch     = ~2'(ch);
        cfgIf.cfg_period = ~CNT_W'(period);
        cfgIf.cfg_en     = ~en;
        if (hold) begin
            @(posedge clk);
            #1;
        end
        cfgIf.cfg_valid = 1'b0;
    endtask

    task automatic doReset(input int n);
        int sCyc;
        while (cyc < segEnd) begin
            @(posedge clk);
            #1;
        end
        rst  = 1'b1;
        sCyc = cyc;
        while (hsQ.size() > 0 && hsQ[$].cyc > sCyc) void'(hsQ.pop_back());
        for (int i = 0; i < 6; i++) begin
            while (tq[i].size() > 0 && tq[i][$] > sCyc) void'(tq[i].pop_back());
            mEn[i]  = 1'b0;
            mPer[i] = 0;
        end
        for (int c = sCyc + 1; c <= sCyc + n; c++) hsQ.push_back('{c, 1'b0, 1'b0, 1'b1});
        hsQ.push_back('{sCyc + n + 1, 1'b1, 1'b0, 1'b1});
        waitCycles(n);
        rst    = 1'b0;
        relCyc = cyc;
    endtask

    always @(negedge clk) begin
        logic [5:0] allTicks;
        bit         expBit;
        allTicks = {tick2, tick1};
        while (hsQ.size() > 0 && hsQ[0].cyc < cyc) void'(hsQ.pop_front());
        if (hsQ.size() > 0 && hsQ[0].cyc == cyc) begin
            checkOutput("cfg_ready dut1", int'(cfgIf.cfg_ready), int'(hsQ[0].ready));
            checkOutput("cfg_ready dut2", int'(cfgIf2.cfg_ready), int'(hsQ[0].ready));
            checkOutput("busy dut1", int'(busy1), int'(hsQ[0].busy));
            checkOutput("busy dut2", int'(busy2), int'(hsQ[0].busy));
            if (hsQ[0].tickZero) begin
                checkOutput("tick_out zero dut1", int'(tick1), 0);
                checkOutput("tick_out zero dut2", int'(tick2), 0);
            end
            void'(hsQ.pop_front());
        end
        for (int i = 0; i < 6; i++) begin
            expBit = (tq[i].size() > 0) && (tq[i][0] == cyc);
            if (expBit || allTicks[i] !== 1'b0) begin
                checkOutput($sformatf("tick dut%0d ch%0d", (i / 4) + 1, i % 4),
                            int'(allTicks[i]), int'(expBit));
                if (expBit) void'(tq[i].pop_front());
            end
        end
    end

    initial begin
        #60000;
        $display("[TB] FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cfgIf.cfg_valid  = 1'b0;
        cfgIf.cfg_ch     = '0;
        cfgIf.cfg_period = '0;
        cfgIf.cfg_en     = 1'b0;
        doReset(3);

        $display("[TB] basic period with held cfg_valid");
        segEnd = relCyc + 70;
        applyStimulus(0, 3, 1'b1, 1'b1);
        doReset(2);

        $display("[TB] runtime period change");
        segEnd = relCyc + 100;
        applyStimulus(0, 3, 1'b1, 1'b0);
        applyStimulus(1, 5, 1'b1, 1'b0);
        waitCycles(30);
        applyStimulus(1, 2, 1'b1, 1'b0);
        doReset(2);

        $display("[TB] disable, zero period, out-of-range index, max period");
        segEnd = relCyc + 110;
        applyStimulus(0, 2, 1'b1, 1'b0);
        waitCycles(20);
        applyStimulus(0, 2, 1'b0, 1'b0);
        waitCycles(16);
        applyStimulus(0, 0, 1'b1, 1'b0);
        waitCycles(16);
        applyStimulus(3, 1, 1'b1, 1'b0);
        applyStimulus(2, 131071, 1'b1, 1'b0);
        doReset(2);

        $display("[TB] write to a third channel while two run");
        segEnd = relCyc + 80;
        applyStimulus(0, 2, 1'b1, 1'b0);
        applyStimulus(1, 4, 1'b1, 1'b0);
        waitCycles(22);
        applyStimulus(2, 3, 1'b1, 1'b0);
        doReset(2);

        $display("[TB] reset while a write is pending");
        segEnd = relCyc + 40;
        applyStimulus(0, 1, 1'b1, 1'b0);
        segEnd = cyc;
        doReset(2);
        segEnd = relCyc + 30;
        waitCycles(30);

        for (int i = 0; i < 6; i++) checkOutput($sformatf("leftover ticks q%0d", i), tq[i].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
